// File: rtl/audio_pkg.sv
// Shared audio-interface definitions: slot geometry and the transmitter framing states.
package audio_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int SLOT_CNT_W = $clog2(SLOT_BITS);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/i2s_tx_shifter.sv
// Serial word shifter: loads a slot word, presents MSB first, then zero-fills until the next load.
module i2s_tx_shifter #(
    parameter int BITSIZE = 24
) (
    input  logic               bclk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               load,
    input  logic [BITSIZE-1:0] word,
    output logic               sdata
);

    logic [BITSIZE-1:0] shreg;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            shreg <= '0;
            sdata <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            sdata <= 1'b0;
        end else if (load) begin
            sdata <= word[BITSIZE-1];
            shreg <= {word[BITSIZE-2:0], 1'b0};
        end else begin
            // Zero fill falls out of the left shift once the word is exhausted.
            sdata <= shreg[BITSIZE-1];
            shreg <= {shreg[BITSIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: follows the codec's lrclk, serialises the active stereo pair and handles
// the upstream sample handshake (request, underrun, framing error).
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int BITSIZE = 24
) (
    input  logic                      bclk,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic                      lrclk,
    input  logic signed [BITSIZE-1:0] left_in,
    input  logic signed [BITSIZE-1:0] right_in,
    input  logic                      sample_valid,
    output logic                      sdata,
    output logic                      sample_req,
    output logic                      underrun,
    output logic                      frame_err
);

    if (BITSIZE < 16 || BITSIZE > 32) begin : g_bitsize_check
        $error("i2s_transmitter: BITSIZE %0d outside legal range 16..32", BITSIZE);
    end

    localparam logic [SLOT_CNT_W-1:0] CNT_MAX = SLOT_CNT_W'(SLOT_BITS - 1);

    tx_state_t state_q, state_d;

    logic                      lr_q;
    logic                      lr_edge;
    logic                      left_start;
    logic [SLOT_CNT_W-1:0]     bit_cnt;
    logic signed [BITSIZE-1:0] pend_l, pend_r;
    logic signed [BITSIZE-1:0] act_l, act_r;
    logic                      fresh_q;

    logic                      slot_start;
    logic                      take_pair;
    logic                      clear_sh;
    logic                      frame_err_d;
    logic [BITSIZE-1:0]        slot_word;

    assign lr_edge    = (lrclk != lr_q);
    assign left_start = lr_edge && !lrclk;

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) state_q <= SYNC;
        else         state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        slot_start  = 1'b0;
        take_pair   = 1'b0;
        clear_sh    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            SYNC: begin
                clear_sh = 1'b1;
                if (left_start) begin
                    state_d    = RUN;
                    slot_start = 1'b1;
                    take_pair  = 1'b1;
                    clear_sh   = 1'b0;
                end
            end
            RUN: begin
                if (lr_edge) begin
                    slot_start  = 1'b1;
                    take_pair   = !lrclk;
                    frame_err_d = (bit_cnt != CNT_MAX);
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Left word comes from the pair that becomes active at this very edge.
    always_comb begin
        slot_word = '0;
        if (enable) begin
            if (!lrclk) slot_word = fresh_q ? pend_l : act_l;
            else        slot_word = act_r;
        end
    end

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            lr_q       <= 1'b0;
            bit_cnt    <= '0;
            pend_l     <= '0;
            pend_r     <= '0;
            act_l      <= '0;
            act_r      <= '0;
            fresh_q    <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            lr_q <= lrclk;

            if (slot_start || state_q == SYNC) bit_cnt <= '0;
            else if (bit_cnt != CNT_MAX)       bit_cnt <= bit_cnt + SLOT_CNT_W'(1);

            // A coincident strobe still wins the flag; the frame uses the prior pending pair.
            if (sample_valid) begin
                pend_l  <= left_in;
                pend_r  <= right_in;
                fresh_q <= 1'b1;
            end else if (take_pair) begin
                fresh_q <= 1'b0;
            end

            if (take_pair && fresh_q) begin
                act_l <= pend_l;
                act_r <= pend_r;
            end

            sample_req <= take_pair;
            underrun   <= take_pair && !fresh_q;
            frame_err  <= frame_err_d;
        end
    end

    i2s_tx_shifter #(
        .BITSIZE(BITSIZE)
    ) u_shifter (
        .bclk  (bclk),
        .resetn(resetn),
        .clear (clear_sh),
        .load  (slot_start),
        .word  (slot_word),
        .sdata (sdata)
    );

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: a slot driver queues the expected per-cycle outputs,
// an independent monitor pops and compares them one cycle at a time.
module tb_i2s_transmitter;

  localparam int W = 24;

  logic                bclk = 1'b0;
  logic                resetn;
  logic                enable;
  logic                lrclk;
  logic signed [W-1:0] left_in;
  logic signed [W-1:0] right_in;
  logic                sample_valid;
  logic                sdata;
  logic                sample_req;
  logic                underrun;
  logic                frame_err;

  i2s_transmitter #(
    .BITSIZE(W)
  ) dut (
    .bclk        (bclk),
    .resetn      (resetn),
    .enable      (enable),
    .lrclk       (lrclk),
    .left_in     (left_in),
    .right_in    (right_in),
    .sample_valid(sample_valid),
    .sdata       (sdata),
    .sample_req  (sample_req),
    .underrun    (underrun),
    .frame_err   (frame_err)
  );

  always #5 bclk = ~bclk;

  typedef struct {
    logic [3:0] val;   // {sdata, sample_req, underrun, frame_err}
    int         slot;
    int         bitn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   slot_no = 0;
  bit   done    = 1'b0;

  // Pending in-slot actions, consumed and cleared by run_slot
  int           sv_at = -1, sv2_at = -1, en_at = -1, rst_at = -1, rst_rel = -1;
  logic [W-1:0] sv_l, sv_r, sv2_l, sv2_r;
  logic         en_val;

  localparam logic [W-1:0] L1 = 24'h800001, R1 = 24'h7FFFFE;
  localparam logic [W-1:0] L2 = 24'h123456, R2 = 24'hABCDEF;
  localparam logic [W-1:0] L3 = 24'hC3A55A, R3 = 24'h0F0F0F;
  localparam logic [W-1:0] L4 = 24'h5A5A5A, R4 = 24'hA5A5A5;
  localparam logic [W-1:0] L5 = 24'h00FF00, R5 = 24'hFF00FF;

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", what, got, req);
    end
  endtask

  // Monitor: compares the DUT outputs 2 time units after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge bclk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("slot%0d bit%0d sdata/req/und/ferr", e.slot, e.bitn),
              32'({sdata, sample_req, underrun, frame_err}), 32'(e.val));
      end
    end
  end

  // Watchdog: the directed sequence must finish well inside this bound
  initial begin
    #200000;
    check("watchdog: stimulus completed before timeout", 32'(done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge bclk);
      e.val = 4'b0000; e.slot = slot_no; e.bitn = i;
      exp_q.push_back(e);
    end
    slot_no++;
  endtask

  task automatic strobe(input int at, input logic [W-1:0] l, input logic [W-1:0] r);
    sv_at = at; sv_l = l; sv_r = r;
  endtask

  task automatic strobe2(input int at, input logic [W-1:0] l, input logic [W-1:0] r);
    sv2_at = at; sv2_l = l; sv2_r = r;
  endtask

  // One lrclk slot of len bclk cycles; word bits at or beyond cut are expected as zero.
  task automatic run_slot(input logic lr, input int len, input logic [W-1:0] word,
                          input logic req = 1'b0, input logic und = 1'b0,
                          input logic ferr = 1'b0, input int cut = 32);
    exp_t e;
    logic b;
    for (int i = 0; i < len; i++) begin
      @(negedge bclk);
      if (i == 0) lrclk = lr;
      sample_valid = 1'b0;
      if (i == sv_at) begin
        sample_valid = 1'b1; left_in = sv_l; right_in = sv_r;
      end
      if (i == sv2_at) begin
        sample_valid = 1'b1; left_in = sv2_l; right_in = sv2_r;
      end
      if (i == en_at)   enable = en_val;
      if (i == rst_at)  resetn = 1'b0;
      if (i == rst_rel) resetn = 1'b1;
      b = (i < cut && i < W) ? word[W-1-i] : 1'b0;
      e.val  = (i == 0) ? {b, req, und, ferr} : {b, 3'b000};
      e.slot = slot_no;
      e.bitn = i;
      exp_q.push_back(e);
    end
    sv_at = -1; sv2_at = -1; en_at = -1; rst_at = -1; rst_rel = -1;
    slot_no++;
  endtask

  initial begin
    resetn       = 1'b0;
    enable       = 1'b1;
    lrclk        = 1'b1;
    sample_valid = 1'b0;
    left_in      = '0;
    right_in     = '0;

    #1;
    check("reset state sdata/req/und/ferr",
          32'({sdata, sample_req, underrun, frame_err}), 32'd0);

    idle(4);

    // Release into a right slot: SYNC stays silent; second strobe overwrites the first
    rst_rel = 0;
    strobe(3, 24'h111111, 24'h222222);
    strobe2(9, L1, R1);
    run_slot(1'b1, 32, '0);

    run_slot(1'b0, 32, L1, 1'b1, 1'b0);
    run_slot(1'b1, 32, R1);

    // Three frames with no new pair: underrun each frame, same words repeat
    run_slot(1'b0, 32, L1, 1'b1, 1'b1);
    run_slot(1'b1, 32, R1);
    run_slot(1'b0, 32, L1, 1'b1, 1'b1);
    run_slot(1'b1, 32, R1);
    run_slot(1'b0, 32, L1, 1'b1, 1'b1);
    strobe(5, L2, R2);
    run_slot(1'b1, 32, R1);

    // Strobe coincident with left start while an earlier pair is fresh
    strobe(0, L3, R3);
    run_slot(1'b0, 32, L2, 1'b1, 1'b0);
    run_slot(1'b1, 32, R2);
    run_slot(1'b0, 32, L3, 1'b1, 1'b0);
    run_slot(1'b1, 32, R3);

    // Short slot flags a framing error; long slot saturates the counter without one
    run_slot(1'b0, 20, L3, 1'b1, 1'b1);
    run_slot(1'b1, 40, R3, 1'b0, 1'b0, 1'b1);
    run_slot(1'b0, 32, L3, 1'b1, 1'b1);
    run_slot(1'b1, 32, R3);

    // Mute mid-left-slot, unmute mid-right-slot: changes only land on slot edges
    en_at = 8; en_val = 1'b0;
    run_slot(1'b0, 32, L3, 1'b1, 1'b1);
    run_slot(1'b1, 32, '0);
    run_slot(1'b0, 32, '0, 1'b1, 1'b1);
    en_at = 10; en_val = 1'b1;
    strobe(12, L4, R4);
    run_slot(1'b1, 32, '0);
    run_slot(1'b0, 32, L4, 1'b1, 1'b0);

    // Reset at bit 10 of a right slot, held past the next left start
    rst_at = 10;
    run_slot(1'b1, 32, R4, 1'b0, 1'b0, 1'b0, 10);
    rst_rel = 5;
    run_slot(1'b0, 32, '0);
    strobe(4, L5, R5);
    run_slot(1'b1, 32, '0);
    run_slot(1'b0, 32, L5, 1'b1, 1'b0);
    run_slot(1'b1, 32, R5);

    @(posedge bclk);
    #4;
    done = 1'b1;
    check("expected-vector queue drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
